// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and helpers for the multi-cycle adder sequencer.
//   state_e      - controller states (IDLE, RUN, DONE)
//   DEF_WIDTH    - default operand/result width
//   DEF_SLICE    - default width of the shared adder slice
//   nslice_f     - number of beats per operation
//   idx_width_f  - beat-index register width (never below 1 bit)
package add_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nslice_f(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-beat configuration still needs a 1-bit index register.
    function automatic int idx_width_f(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_slice_adder.sv
// slice_adder: combinational W-bit adder with carry in and carry out.
// Ports:
//   a, b  - W-bit slice operands
//   cin   - carry into bit 0
//   s     - W-bit slice sum
//   cout  - carry out of bit W-1
module slice_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] sum_w;

    assign sum_w = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s     = sum_w[W-1:0];
    assign cout  = sum_w[W];

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: WIDTH-bit adder that time-shares one SLICE-bit adder over
// NSLICE beats, LSB slice first, with the carry held in a register between
// beats. One operation in flight; valid/ready on both sides.
//
// Optional build macro ADD_SUB_EN: adds the sub input. When sub is high on
// accept, b is inverted slice by slice and the first carry-in is 1, giving
// a - b; cout=1 then means no borrow. Without the macro the block only adds.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - operand handshake; a, b (and sub) sampled on accept
//   out_valid/out_ready - result handshake; sum, cout held while out_valid
//   busy                - high while an operation is in RUN or DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one slice added per cycle, idx selects the slice
// DONE  | result presented until out_ready, no new accepts
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = nslice_f(WIDTH, SLICE);
    localparam int IDX_W  = idx_width_f(NSLICE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("add_seq_ctrl: WIDTH must be a multiple of SLICE");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
`ifdef ADD_SUB_EN
    logic               sub_q, sub_d;
`endif

    int                 base;
    logic [SLICE-1:0]   sl_a;
    logic [SLICE-1:0]   sl_b;
    logic [SLICE-1:0]   sl_s;
    logic               sl_c;

    assign base = int'(idx_q) * SLICE;
    assign sl_a = a_q[base +: SLICE];
`ifdef ADD_SUB_EN
    // Inverting b plus an initial carry of 1 forms the two's complement.
    assign sl_b = b_q[base +: SLICE] ^ {SLICE{sub_q}};
`else
    assign sl_b = b_q[base +: SLICE];
`endif

    slice_adder #(
        .W (SLICE)
    ) u_slice_adder (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef ADD_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    res_d   = '0;
`ifdef ADD_SUB_EN
                    sub_d   = sub;
                    carry_d = sub;
`else
                    carry_d = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[base +: SLICE] = sl_s;
                carry_d = sl_c;
                if (idx_q == IDX_LAST) begin
                    // Output registers only change here, so sum/cout hold
                    // the previous result while the next one is computed.
                    sum_d   = res_d;
                    cout_d  = sl_c;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: a vector table of operand pairs with
// hand-computed results, plus directed backpressure and mid-run reset cases.
module tb_add_seq_ctrl;

    localparam int WIDTH  = 32;
    localparam int NSLICE = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
`ifdef ADD_SUB_EN
    logic             sub_i = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(
        .WIDTH (WIDTH),
        .SLICE (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef ADD_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Waits at negedges for out_valid; returns the number of clock edges
    // after the accept edge, capped so a stuck DUT still ends the run.
    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int k;
        @(negedge clk);
        a = v.a;
        b = v.b;
`ifdef ADD_SUB_EN
        sub_i = v.sub;
`endif
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
`ifdef ADD_SUB_EN
        sub_i = ~v.sub;
`endif
        wait_valid(k);
        chk({tag, "_latency"}, 64'(k), 64'(NSLICE));
        chk({tag, "_sum"}, 64'(sum), 64'(v.exp_sum));
        chk({tag, "_cout"}, 64'(cout), 64'(v.exp_cout));
        chk({tag, "_busy_done"}, {62'd0, busy, in_ready}, {62'd0, 1'b1, 1'b0});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_released"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        chk({tag, "_sum_held"}, 64'(sum), 64'(v.exp_sum));
    endtask

    initial begin
        int k;
        vec_t v;

        vecs.push_back('{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1});
        vecs.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0});
`ifdef ADD_SUB_EN
        vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1});
`endif

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_flags", {60'd0, cout, out_valid, busy, in_ready}, {60'd0, 4'b0001});
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_flags", {60'd0, cout, out_valid, busy, in_ready}, {60'd0, 4'b0001});

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE for 10 cycles with a pending new request
        @(negedge clk);
        a = 32'h0000_0001;
        b = 32'h0000_0002;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h0000_0100;
        b = 32'h0000_0200;
        wait_valid(k);
        chk("bp_latency", 64'(k), 64'(NSLICE));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", c),
                {30'd0, cout, out_valid, in_ready, sum},
                {30'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0003});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accepted", {62'd0, busy, in_ready}, {62'd0, 1'b1, 1'b0});
        wait_valid(k);
        chk("bp_new_latency", 64'(k), 64'(NSLICE));
        chk("bp_new_sum", {31'd0, cout, sum}, {31'd0, 1'b0, 32'h0000_0300});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN
        @(negedge clk);
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_flags", {60'd0, cout, out_valid, busy, in_ready}, {60'd0, 4'b0001});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_no_result", {61'd0, out_valid, busy, in_ready}, {61'd0, 3'b001});
        v = '{32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0};
        run_op(v, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
